axis_buf_streamer: RTL and testbench

- Parametrised master-side feeder for neural_acc_v1_0: reads frames from an input-buffer BRAM (1-cycle read latency) and drives an AXI-Stream master with tlast.
- Supports runtime base address and frame length, back-pressure-safe prefetch, optional wait-for-done between frames, and frame counting.
- Sits between blk_mem_gen input buffers and the accelerator's s00_axis port; replaces ad-hoc address/tvalid counters.

---
 rtl/streamer_pkg.sv | 14 +
 rtl/streamer_skid_fifo.sv | 50 +++++
 rtl/axis_buf_streamer.sv | 180 ++++++++++++++++++
 tb/tb_axis_buf_streamer.sv | 366 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/streamer_pkg.sv
// Shared types and constants for axis_buf_streamer and its skid FIFO.
package streamer_pkg;

   typedef enum logic [1:0] {
      S_IDLE,
      S_STREAM,
      S_DRAIN,
      S_WAIT_DONE
   } state_e;

   localparam int FIFO_DEPTH = 2;
   localparam int OCC_W      = $clog2(FIFO_DEPTH + 1);

endpackage

// File: rtl/streamer_skid_fifo.sv
// Two-entry FIFO holding prefetched beats (data plus last flag) ahead of the
// AXI-Stream handshake. The owner never pushes when full or pops when empty.
module streamer_skid_fifo
   import streamer_pkg::*;
#(
   parameter int W = 33
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push_i,
   input  logic [W-1:0]     data_i,
   input  logic             pop_i,
   output logic [W-1:0]     data_o,
   output logic [OCC_W-1:0] occ_o,
   output logic             valid_o
);

   // Pointers are one bit wide because the depth is fixed at two.
   logic [W-1:0]     mem_q [FIFO_DEPTH];
   logic             wr_ptr_q;
   logic             rd_ptr_q;
   logic [OCC_W-1:0] occ_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         // NOTE: storage is reset as well so tdata reads 0 out of reset.
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         occ_q    <= '0;
      end else begin
         // NOTE: non-blocking so every register samples pre-edge values.
         if (push_i) begin
            mem_q[wr_ptr_q] <= data_i;
            wr_ptr_q        <= ~wr_ptr_q;
         end
         if (pop_i) begin
            rd_ptr_q <= ~rd_ptr_q;
         end
         occ_q <= occ_q + OCC_W'(push_i) - OCC_W'(pop_i);
      end
   end

   assign data_o  = mem_q[rd_ptr_q];
   assign occ_o   = occ_q;
   assign valid_o = (occ_q != '0);

endmodule

// File: rtl/axis_buf_streamer.sv
// BRAM-to-AXI-Stream frame feeder with prefetch, tlast and optional wait-for-done.
// Define STREAMER_STALL_CNT_EN to add the stall_cnt output.
module axis_buf_streamer
   import streamer_pkg::*;
#(
   parameter int DATA_W    = 32,
   parameter int ADDR_W    = 10,
   parameter int WAIT_DONE = 1,
   parameter int CNT_W     = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W:0]   frame_len,
   output logic              mem_en,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [DATA_W-1:0] m_axis_tdata,
   output logic              m_axis_tvalid,
   input  logic              m_axis_tready,
   output logic              m_axis_tlast,
   input  logic              acc_done,
   output logic              busy,
   output logic              frame_done,
   output logic [CNT_W-1:0]  frame_cnt
`ifdef STREAMER_STALL_CNT_EN
   ,
   output logic [31:0]       stall_cnt
`endif
);

   localparam int LEN_W = ADDR_W + 1;
   localparam int LVL_W = OCC_W + 1;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] base_q, base_d;
   logic [LEN_W-1:0]  len_q, len_d;
   logic [LEN_W-1:0]  rd_idx_q, rd_idx_d;
   logic              inflight_q;
   logic              inflight_last_q;
   logic              frame_done_q, frame_done_d;
   logic [CNT_W-1:0]  frame_cnt_q, frame_cnt_d;

   logic [DATA_W:0]   head;
   logic [OCC_W-1:0]  occ;
   logic              fifo_valid;
   logic              pop;
   logic              rd_en;
   logic              rd_is_last;
   logic              start_acc;
   logic [LVL_W-1:0]  level;

   // level is the FIFO occupancy after this edge, counting the read in flight.
   always_comb begin
      pop        = fifo_valid && m_axis_tready;
      level      = {1'b0, occ} + LVL_W'(inflight_q) - LVL_W'(pop);
      rd_is_last = (rd_idx_q == len_q - LEN_W'(1));
      rd_en      = en && (state_q == S_STREAM) && (rd_idx_q < len_q)
                   && (level < LVL_W'(FIFO_DEPTH));
      start_acc  = en && start && (state_q == S_IDLE);
   end

   always_comb begin
      // NOTE: defaults first so every path assigns every output (no latches).
      state_d      = state_q;
      base_d       = base_q;
      len_d        = len_q;
      rd_idx_d     = rd_idx_q;
      frame_done_d = 1'b0;
      frame_cnt_d  = frame_cnt_q;
      if (rd_en) begin
         rd_idx_d = rd_idx_q + LEN_W'(1);
      end
      case (state_q)
         S_IDLE: begin
            if (start_acc) begin
               if (frame_len != '0) begin
                  state_d  = S_STREAM;
                  base_d   = base_addr;
                  len_d    = frame_len;
                  rd_idx_d = '0;
               end else begin
                  frame_done_d = 1'b1;
               end
            end
         end
         S_STREAM: begin
            if (rd_en && rd_is_last) begin
               state_d = S_DRAIN;
            end
         end
         S_DRAIN: begin
            // Completion follows the tlast handshake even while en is low.
            if (pop && head[DATA_W]) begin
               if (WAIT_DONE != 0) begin
                  state_d = S_WAIT_DONE;
               end else begin
                  state_d      = S_IDLE;
                  frame_done_d = 1'b1;
                  frame_cnt_d  = frame_cnt_q + CNT_W'(1);
               end
            end
         end
         S_WAIT_DONE: begin
            if (acc_done) begin
               state_d      = S_IDLE;
               frame_done_d = 1'b1;
               frame_cnt_d  = frame_cnt_q + CNT_W'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q         <= S_IDLE;
         base_q          <= '0;
         len_q           <= '0;
         rd_idx_q        <= '0;
         inflight_q      <= 1'b0;
         inflight_last_q <= 1'b0;
         frame_done_q    <= 1'b0;
         frame_cnt_q     <= '0;
      end else begin
         state_q      <= state_d;
         base_q       <= base_d;
         len_q        <= len_d;
         rd_idx_q     <= rd_idx_d;
         inflight_q   <= rd_en;
         frame_done_q <= frame_done_d;
         frame_cnt_q  <= frame_cnt_d;
         if (rd_en) begin
            inflight_last_q <= rd_is_last;
         end
      end
   end

   // The word read last cycle is always captured, whatever en does now.
   streamer_skid_fifo #(
      .W (DATA_W + 1)
   ) u_skid (
      .clk     (clk),
      .rst     (rst),
      .push_i  (inflight_q),
      .data_i  ({inflight_last_q, mem_rdata}),
      .pop_i   (pop),
      .data_o  (head),
      .occ_o   (occ),
      .valid_o (fifo_valid)
   );

   assign mem_en        = rd_en;
   assign mem_addr      = base_q + rd_idx_q[ADDR_W-1:0];
   assign m_axis_tvalid = fifo_valid;
   assign m_axis_tdata  = head[DATA_W-1:0];
   assign m_axis_tlast  = head[DATA_W];
   assign busy          = (state_q != S_IDLE);
   assign frame_done    = frame_done_q;
   assign frame_cnt     = frame_cnt_q;

`ifdef STREAMER_STALL_CNT_EN
   logic [31:0] stall_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_q <= '0;
      end else if (start_acc) begin
         stall_q <= '0;
      end else if (fifo_valid && !m_axis_tready && (stall_q != '1)) begin
         stall_q <= stall_q + 32'd1;
      end
   end

   assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_axis_buf_streamer.sv
// Self-checking bench for axis_buf_streamer: directed frames plus randomized
// traffic compared every cycle against a queue-based frame model.
module tb_axis_buf_streamer;

   localparam int DATA_W      = 32;
   localparam int ADDR_W      = 10;
   localparam int CNT_W       = 16;
   localparam int WAIT_DONE_P = 1;
   localparam int DEPTH       = 1 << ADDR_W;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              en = 1'b1;
   logic              start = 1'b0;
   logic [ADDR_W-1:0] base_addr = '0;
   logic [ADDR_W:0]   frame_len = '0;
   logic              mem_en;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_rdata = '0;
   logic [DATA_W-1:0] m_axis_tdata;
   logic              m_axis_tvalid;
   logic              m_axis_tready = 1'b1;
   logic              m_axis_tlast;
   logic              acc_done = 1'b0;
   logic              busy;
   logic              frame_done;
   logic [CNT_W-1:0]  frame_cnt;
`ifdef STREAMER_STALL_CNT_EN
   logic [31:0]       stall_cnt;
`endif

   axis_buf_streamer #(
      .DATA_W    (DATA_W),
      .ADDR_W    (ADDR_W),
      .WAIT_DONE (WAIT_DONE_P),
      .CNT_W     (CNT_W)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .en            (en),
      .start         (start),
      .base_addr     (base_addr),
      .frame_len     (frame_len),
      .mem_en        (mem_en),
      .mem_addr      (mem_addr),
      .mem_rdata     (mem_rdata),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tready (m_axis_tready),
      .m_axis_tlast  (m_axis_tlast),
      .acc_done      (acc_done),
      .busy          (busy),
      .frame_done    (frame_done),
      .frame_cnt     (frame_cnt)
`ifdef STREAMER_STALL_CNT_EN
      ,
      .stall_cnt     (stall_cnt)
`endif
   );

   always #5 clk = ~clk;

   // Input buffer: one-cycle read latency.
   logic [DATA_W-1:0] bram [DEPTH];
   always @(posedge clk) begin
      if (mem_en) mem_rdata <= bram[mem_addr];
   end

   int n_checks = 0;
   int n_err    = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- frame model ----------------
   typedef struct packed {
      logic              last;
      logic [DATA_W-1:0] data;
   } beat_t;

   beat_t             exp_q[$];
   beat_t             mon_b;
   beat_t             prev_head;
   bit                prev_stall = 0;
   bit                m_busy = 0, m_done = 0, wait_acc = 0;
   bit                cur_busy, next_done, tlast_hs;
   int                m_cnt = 0;
   logic [31:0]       m_stall = '0;
   int                rd_base = 0, rd_len = 0, rd_cnt = 0;
   int                cyc = 0, accept_cyc = 0, first_tv_cyc = 0, first_me_cyc = 0;
   bit                tv_seen = 0, me_seen = 0, any_tv = 0;
   logic [DATA_W-1:0] got_data[$];
   bit                got_last[$];
   int                got_cyc[$];
   int                addr_log[$];
   int                hs_n = 0;

   always @(negedge clk) begin
      cyc++;
      if (rst) begin
         check("rst_tvalid", 64'(m_axis_tvalid), 0);
         check("rst_busy", 64'(busy), 0);
         check("rst_mem_en", 64'(mem_en), 0);
         check("rst_frame_done", 64'(frame_done), 0);
         check("rst_frame_cnt", 64'(frame_cnt), 0);
         exp_q.delete();
         m_busy = 0; m_done = 0; wait_acc = 0; m_cnt = 0; m_stall = '0;
         rd_len = 0; rd_cnt = 0; prev_stall = 0;
      end else begin
         check("busy", 64'(busy), 64'(m_busy));
         check("frame_done", 64'(frame_done), 64'(m_done));
         check("frame_cnt", 64'(frame_cnt), 64'(m_cnt[CNT_W-1:0]));
`ifdef STREAMER_STALL_CNT_EN
         check("stall_cnt", 64'(stall_cnt), 64'(m_stall));
`endif
         if (prev_stall)
            check("hold_stable", 64'({m_axis_tvalid, m_axis_tlast, m_axis_tdata}),
                  64'({1'b1, prev_head}));
         if (mem_en) begin
            check("mem_en_needs_en", 64'(en), 1);
            check("read_in_range", 64'(rd_cnt < rd_len), 1);
            check("mem_addr", 64'(mem_addr), 64'((rd_base + rd_cnt) % DEPTH));
            if (!me_seen) begin me_seen = 1; first_me_cyc = cyc; end
            addr_log.push_back(int'(mem_addr));
            rd_cnt++;
         end
         tlast_hs = 0;
         if (m_axis_tvalid) begin
            any_tv = 1;
            if (!tv_seen) begin tv_seen = 1; first_tv_cyc = cyc; end
            check("tvalid_has_pending_beat", 64'(exp_q.size() > 0), 1);
            if (m_axis_tready && exp_q.size() > 0) begin
               mon_b = exp_q.pop_front();
               check("beat", 64'({m_axis_tlast, m_axis_tdata}), 64'(mon_b));
               got_data.push_back(m_axis_tdata);
               got_last.push_back(m_axis_tlast);
               got_cyc.push_back(cyc);
               hs_n++;
               tlast_hs = mon_b.last;
            end
         end
         prev_stall = m_axis_tvalid && !m_axis_tready;
         prev_head  = {m_axis_tlast, m_axis_tdata};

         // Model state for the next cycle.
         cur_busy  = m_busy;
         next_done = 0;
         if (wait_acc && acc_done) begin
            next_done = 1; m_cnt++; wait_acc = 0; m_busy = 0;
         end
         if (tlast_hs) begin
            if (WAIT_DONE_P != 0) wait_acc = 1;
            else begin next_done = 1; m_cnt++; m_busy = 0; end
         end
         if (!cur_busy && start && en) begin
            m_stall = '0;
            if (frame_len == 0) begin
               next_done = 1;
            end else begin
               m_busy = 1;
               rd_base = int'(base_addr); rd_len = int'(frame_len); rd_cnt = 0;
               accept_cyc = cyc; tv_seen = 0; me_seen = 0;
               for (int i = 0; i < int'(frame_len); i++) begin
                  mon_b.data = bram[(int'(base_addr) + i) % DEPTH];
                  mon_b.last = (i == int'(frame_len) - 1);
                  exp_q.push_back(mon_b);
               end
            end
         end else if (prev_stall && m_stall != '1) begin
            m_stall = m_stall + 1;
         end
         m_done = next_done;
      end
   end

   // ---------------- stimulus ----------------
   int tready_mode = 0;  // 0 high, 1 pattern 1,0,0,1, 2 random, 3 low
   int pat_i = 0;
   bit acc_rand = 0, en_rand = 0, stray = 0;

   task automatic apply_tready();
      case (tready_mode)
         0: m_axis_tready = 1'b1;
         1: m_axis_tready = (pat_i % 4 == 0) || (pat_i % 4 == 3);
         2: m_axis_tready = 1'($urandom_range(0, 1));
         default: m_axis_tready = 1'b0;
      endcase
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      start = 1'b0;
      pat_i++;
      apply_tready();
      acc_done = acc_rand && ($urandom_range(0, 5) == 0);
      if (en_rand) en = ($urandom_range(0, 5) != 0);
      if (stray && m_busy && $urandom_range(0, 9) == 0) begin
         start = 1'b1;
         base_addr = ADDR_W'($urandom);
         frame_len = (ADDR_W+1)'($urandom_range(1, 20));
      end
   endtask

   task automatic wait_idle(input int budget);
      int n = 0;
      while ((m_busy || exp_q.size() != 0) && n < budget) begin
         tick();
         n++;
      end
      check("frame_completes", 64'(m_busy || exp_q.size() != 0), 0);
   endtask

   task automatic send(input int base, input int len);
      wait_idle(3000);
      start = 1'b1;
      en = 1'b1;
      base_addr = ADDR_W'(base);
      frame_len = (ADDR_W+1)'(len);
      tick();
   endtask

   task automatic clear_logs();
      got_data.delete(); got_last.delete(); got_cyc.delete(); addr_log.delete();
      hs_n = 0; any_tv = 0;
   endtask

   task automatic wait_hs(input int n);
      int k = 0;
      while (hs_n < n && k < 200) begin tick(); k++; end
      check("reach_handshake", 64'(hs_n >= n), 1);
   endtask

   logic [CNT_W-1:0] cnt0;

   initial begin
      for (int i = 0; i < DEPTH; i++) bram[i] = DATA_W'(i + 100);
      repeat (3) tick();
      check("reset_tvalid_direct", 64'(m_axis_tvalid), 0);
      rst = 1'b0;
      tick();

      // Basic frame, WAIT_DONE with acc_done 5 cycles after tlast.
      clear_logs();
      send(0, 4);
      for (int k = 0; k < 100 && !wait_acc; k++) tick();
      check("basic_waiting_busy", 64'(busy), 1);
      check("basic_beats", 64'(got_data.size()), 4);
      check("basic_beat0", 64'(got_data[0]), 100);
      check("basic_beat3", 64'(got_data[3]), 103);
      check("basic_last0", 64'(got_last[0]), 0);
      check("basic_last3", 64'(got_last[3]), 1);
      check("basic_back_to_back", 64'(got_cyc[3] - got_cyc[0]), 3);
      check("basic_mem_en_latency", 64'(first_me_cyc - accept_cyc), 1);
      check("basic_tvalid_latency", 64'(first_tv_cyc - accept_cyc), 3);
      repeat (5) tick();
      acc_done = 1'b1;
      tick();
      check("basic_frame_done", 64'(frame_done), 1);
      check("basic_frame_cnt", 64'(frame_cnt), 1);
      tick();
      check("basic_done_one_cycle", 64'(frame_done), 0);
      check("basic_idle", 64'(busy), 0);

      // Back-pressure with tready 1,0,0,1.
      acc_rand = 1;
      clear_logs();
      tready_mode = 1;
      send(5, 8);
      wait_idle(500);
      check("bp_beats", 64'(got_data.size()), 8);
      for (int i = 0; i < 8 && i < got_data.size(); i++)
         check("bp_order", 64'(got_data[i]), 64'(105 + i));
      tready_mode = 0;

      // Address wrap.
      clear_logs();
      send(1022, 4);
      wait_idle(500);
      check("wrap_nreads", 64'(addr_log.size()), 4);
      check("wrap_addr0", 64'(addr_log[0]), 1022);
      check("wrap_addr1", 64'(addr_log[1]), 1023);
      check("wrap_addr2", 64'(addr_log[2]), 0);
      check("wrap_addr3", 64'(addr_log[3]), 1);
      check("wrap_data2", 64'(got_data[2]), 100);
      check("wrap_last3", 64'(got_last[3]), 1);

      // Zero-length frame, then start while streaming.
      wait_idle(500);
      clear_logs();
      cnt0 = frame_cnt;
      send(7, 0);
      check("zero_len_done", 64'(frame_done), 1);
      repeat (4) tick();
      check("zero_len_no_tvalid", 64'(any_tv), 0);
      check("zero_len_cnt_same", 64'(frame_cnt), 64'(cnt0));
      check("zero_len_idle", 64'(busy), 0);
      clear_logs();
      send(100, 6);
      repeat (3) tick();
      start = 1'b1; base_addr = '0; frame_len = 3;
      tick();
      wait_idle(500);
      check("ignored_start_beats", 64'(got_data.size()), 6);
      check("ignored_start_last", 64'(got_data[5]), 205);

      // en low for 6 cycles after beat 2, beat held with tready low.
      clear_logs();
      send(200, 6);
      wait_hs(2);
      en = 1'b0;
      tready_mode = 3;
      apply_tready();
      for (int k = 0; k < 6; k++) begin
         tick();
         check("enlow_tvalid_held", 64'(m_axis_tvalid), 1);
         check("enlow_no_mem_en", 64'(mem_en), 0);
      end
      en = 1'b1;
      tready_mode = 0;
      apply_tready();
      wait_idle(500);
      check("enlow_beats", 64'(got_data.size()), 6);
      check("enlow_last_data", 64'(got_data[5]), 305);

      // Asynchronous reset mid-frame, then a fresh frame.
      clear_logs();
      send(300, 10);
      wait_hs(3);
      #2 rst = 1'b1;
      #1;
      check("async_rst_tvalid", 64'(m_axis_tvalid), 0);
      check("async_rst_busy", 64'(busy), 0);
      check("async_rst_mem_en", 64'(mem_en), 0);
      tick();
      tick();
      rst = 1'b0;
      tick();
      clear_logs();
      send(400, 5);
      wait_idle(500);
      check("post_rst_beats", 64'(got_data.size()), 5);
      check("post_rst_first", 64'(got_data[0]), 500);
      check("post_rst_cnt", 64'(frame_cnt), 1);

      // Randomized traffic.
      for (int i = 0; i < DEPTH; i++) bram[i] = $urandom;
      tready_mode = 2; en_rand = 1; stray = 1;
      for (int f = 0; f < 30; f++) begin
         if ($urandom_range(0, 7) == 0) send(int'($urandom_range(0, DEPTH - 1)), 0);
         else send(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(1, 24)));
         wait_idle(3000);
      end
      tready_mode = 0; en_rand = 0; stray = 0; en = 1'b1;
      repeat (4) tick();

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
